// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC} state_t;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory buses of the arbiter; slave = arbiter side
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic if_req, if_ready, d_req, d_we, d_ready, m_req, m_we, m_ack, stall_if, stall_mem, err;
  logic [AW-1:0] if_addr, d_addr, m_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, m_wdata, m_rdata;
  modport master(
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    input if_ready, if_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, stall_if, stall_mem, err
  );
  modport slave(
    input if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_ack, m_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, m_req, m_we, m_addr, m_wdata, stall_if, stall_mem, err
  );
endinterface

// File: rtl/arb_wait_timer.sv
// arb_wait_timer: saturating wait counter; timeout flags TIMEOUT-1 cycles waited
module arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
  assign timeout = cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !timeout) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store
// ARB_RR_EN selects round-robin on simultaneous requests; default is data over fetch
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave bus
);
  state_t state, nxt;
  logic if_el, d_el, pick_d, to, done, grant;
  assign if_el = bus.if_req & ~bus.if_ready;
  assign d_el = bus.d_req & ~bus.d_ready;
  assign done = bus.m_ack | to;
  assign grant = state == IDLE && nxt != IDLE;
`ifdef ARB_RR_EN
  logic last_grant;
  assign pick_d = d_el & (~if_el | (last_grant == OWN_IF));
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant <= OWN_IF;
    else if (grant) last_grant <= pick_d ? OWN_D : OWN_IF;
`else
  assign pick_d = d_el;
`endif
  always_comb nxt = state == IDLE ? (pick_d ? D_ACC : if_el ? IF_ACC : IDLE) : done ? IDLE : state;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  assign bus.m_req = state != IDLE;
  assign bus.stall_if = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = bus.d_req & ~bus.d_ready;
  arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .clr(state == IDLE), .en(bus.m_req & ~bus.m_ack), .timeout(to)
  );
  // a timed-out access completes like an ack but returns zero data and flags err
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.if_ready <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.err <= 1'b0;
      bus.if_rdata <= {DW{1'b0}};
      bus.d_rdata <= {DW{1'b0}};
      bus.m_we <= 1'b0;
      bus.m_addr <= {AW{1'b0}};
      bus.m_wdata <= {DW{1'b0}};
    end else begin
      bus.if_ready <= state == IF_ACC && done;
      bus.d_ready <= state == D_ACC && done;
      bus.err <= bus.m_req && !bus.m_ack && to;
      if (state == IF_ACC && done) bus.if_rdata <= bus.m_ack ? bus.m_rdata : {DW{1'b0}};
      if (state == D_ACC && done) bus.d_rdata <= bus.m_ack ? bus.m_rdata : {DW{1'b0}};
      if (grant) begin
        bus.m_addr <= pick_d ? bus.d_addr : bus.if_addr;
        bus.m_we <= pick_d & bus.d_we;
        bus.m_wdata <= pick_d ? bus.d_wdata : {DW{1'b0}};
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a cycle-level behavioural model
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;
  localparam int TO = 16;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int checks = 0, failures = 0;
  task automatic ck(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask
  // own: 0 idle, 1 fetch, 2 data; last: 1 when data was granted last
  typedef struct {
    int own;
    int wt;
    logic [31:0] addr, wdata, ifd, dd;
    logic we, ifr, dr, er, last;
  } mdl_t;
  mdl_t m;
  function automatic mdl_t step(input mdl_t c);
    mdl_t n = c;
    logic ei, ed, pd;
    n.ifr = 1'b0;
    n.dr = 1'b0;
    n.er = 1'b0;
    if (c.own == 0) begin
      ei = bus.if_req && !c.ifr;
      ed = bus.d_req && !c.dr;
      pd = ed && (!ei || !RR || !c.last);
      if (pd) begin
        n.own = 2; n.addr = bus.d_addr; n.we = bus.d_we; n.wdata = bus.d_wdata; n.wt = 0; n.last = 1'b1;
      end else if (ei) begin
        n.own = 1; n.addr = bus.if_addr; n.we = 1'b0; n.wt = 0; n.last = 1'b0;
      end
    end else if (bus.m_ack || c.wt == TO - 1) begin
      if (c.own == 1) begin n.ifr = 1'b1; n.ifd = bus.m_ack ? bus.m_rdata : 32'h0; end
      else begin n.dr = 1'b1; n.dd = bus.m_ack ? bus.m_rdata : 32'h0; end
      n.er = !bus.m_ack;
      n.own = 0;
    end else n.wt = c.wt + 1;
    return n;
  endfunction
  always @(posedge clk or negedge rst)
    if (!rst) m <= '{default: 0};
    else m <= step(m);
  always @(negedge clk) begin
    ck("m_req", bus.m_req, m.own != 0);
    if (m.own != 0) begin
      ck("m_addr", bus.m_addr, m.addr);
      ck("m_we", bus.m_we, m.we);
      if (m.we) ck("m_wdata", bus.m_wdata, m.wdata);
    end
    ck("if_ready", bus.if_ready, m.ifr);
    ck("d_ready", bus.d_ready, m.dr);
    ck("err", bus.err, m.er);
    if (m.ifr) ck("if_rdata", bus.if_rdata, m.ifd);
    if (m.dr) ck("d_rdata", bus.d_rdata, m.dd);
    ck("stall_if", bus.stall_if, bus.if_req & ~m.ifr);
    ck("stall_mem", bus.stall_mem, bus.d_req & ~m.dr);
  end
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int n, nr, mcnt, lat;
    bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.m_ack = 0; bus.m_rdata = 0;
    repeat (2) cyc();
    ck("rst_m_addr", bus.m_addr, 0);
    ck("rst_m_wdata", bus.m_wdata, 0);
    ck("rst_if_rdata", bus.if_rdata, 0);
    rst = 1'b1;
    cyc();
    // single fetch, ack in the second memory cycle
    bus.if_req = 1; bus.if_addr = 32'h40;
    cyc();
    ck("sf_mreq", bus.m_req, 1);
    ck("sf_addr", bus.m_addr, 32'h40);
    ck("sf_we", bus.m_we, 0);
    ck("sf_stall", bus.stall_if, 1);
    cyc();
    ck("sf_stall2", bus.stall_if, 1);
    bus.m_ack = 1; bus.m_rdata = 32'h2002000A;
    cyc();
    ck("sf_ready", bus.if_ready, 1);
    ck("sf_rdata", bus.if_rdata, 32'h2002000A);
    ck("sf_stall_drop", bus.stall_if, 0);
    bus.m_ack = 0; bus.if_req = 0;
    cyc();
    ck("sf_ready_once", bus.if_ready, 0);
    // simultaneous store and fetch right after reset: data first in both modes
    bus.if_req = 1; bus.if_addr = 32'h80;
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEADBEEF;
    cyc();
    ck("sim_we", bus.m_we, 1);
    ck("sim_addr", bus.m_addr, 32'h100);
    ck("sim_wdata", bus.m_wdata, 32'hDEADBEEF);
    bus.m_ack = 1; bus.m_rdata = 32'h11;
    cyc();
    ck("sim_d_first", bus.d_ready, 1);
    ck("sim_if_not_yet", bus.if_ready, 0);
    bus.m_ack = 0; bus.d_req = 0;
    cyc();
    ck("sim_if_addr", bus.m_addr, 32'h80);
    ck("sim_if_we", bus.m_we, 0);
    bus.m_ack = 1; bus.m_rdata = 32'h13;
    cyc();
    ck("sim_if_ready", bus.if_ready, 1);
    ck("sim_if_rdata", bus.if_rdata, 32'h13);
    bus.m_ack = 0; bus.if_req = 0;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200;
    cyc();
    bus.m_ack = 1; bus.m_rdata = 32'h55;
    cyc();
    ck("ld_ready", bus.d_ready, 1);
    ck("ld_rdata", bus.d_rdata, 32'h55);
    bus.m_ack = 0; bus.d_req = 0;
    cyc();
    // after a data grant, round-robin serves fetch first
    bus.if_req = 1; bus.if_addr = 32'h84;
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h204;
    cyc();
    ck("rr_first", bus.m_addr, RR ? 32'h84 : 32'h204);
    bus.m_ack = 1; bus.m_rdata = 32'h66;
    cyc();
    ck("rr_first_rdy", RR ? bus.if_ready : bus.d_ready, 1);
    bus.m_ack = 0;
    if (RR) bus.if_req = 0; else bus.d_req = 0;
    cyc();
    ck("rr_second", bus.m_addr, RR ? 32'h204 : 32'h84);
    bus.m_ack = 1; bus.m_rdata = 32'h77;
    cyc();
    ck("rr_second_rdy", RR ? bus.d_ready : bus.if_ready, 1);
    bus.m_ack = 0; bus.if_req = 0; bus.d_req = 0;
    cyc();
    // held request across its ready cycle: single access
    bus.if_req = 1; bus.if_addr = 32'h44;
    n = 0; nr = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n += int'(bus.m_req);
      nr += int'(bus.if_ready);
      if (i == 0) begin bus.m_ack = 1; bus.m_rdata = 32'h21; end
      if (i == 1) bus.m_ack = 0;
      if (i == 2) bus.if_req = 0;
    end
    ck("held_accesses", n, 1);
    ck("held_readies", nr, 1);
    // timeout on a load
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!bus.m_req) break;
      n++;
    end
    ck("to_cycles", n, 16);
    ck("to_ready", bus.d_ready, 1);
    ck("to_err", bus.err, 1);
    ck("to_rdata", bus.d_rdata, 0);
    bus.d_req = 0;
    bus.if_req = 1; bus.if_addr = 32'h48;
    cyc();
    ck("to_next_grant", bus.m_req, 1);
    ck("to_next_addr", bus.m_addr, 32'h48);
    bus.m_ack = 1; bus.m_rdata = 32'h31;
    cyc();
    bus.m_ack = 0; bus.if_req = 0;
    cyc();
    // reset in the middle of a store, then a late ack
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h400; bus.d_wdata = 32'h1234;
    cyc();
    ck("rm_mreq", bus.m_req, 1);
    rst = 1'b0; bus.d_req = 0;
    #1;
    ck("rm_async_mreq", bus.m_req, 0);
    ck("rm_m_we", bus.m_we, 0);
    ck("rm_m_addr", bus.m_addr, 0);
    ck("rm_m_wdata", bus.m_wdata, 0);
    cyc();
    rst = 1'b1; bus.m_ack = 1; bus.m_rdata = 32'h99;
    cyc();
    bus.m_ack = 0;
    ck("rm_no_ready", bus.d_ready, 0);
    ck("rm_no_err", bus.err, 0);
    ck("rm_idle", bus.m_req, 0);
    cyc();
    ck("rm_still_idle", bus.m_req | bus.d_ready, 0);
    // requester withdraws mid-access
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h500;
    cyc();
    bus.d_req = 0;
    cyc();
    ck("wd_held", bus.m_req, 1);
    bus.m_ack = 1; bus.m_rdata = 32'hA5A5;
    cyc();
    ck("wd_ready", bus.d_ready, 1);
    ck("wd_rdata", bus.d_rdata, 32'hA5A5);
    bus.m_ack = 0;
    cyc();
    ck("wd_no_regrant", bus.m_req | bus.d_ready, 0);
    // randomized traffic with a memory of random latency, sometimes never acking
    mcnt = 0; lat = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (bus.m_req) begin
        if (mcnt == 0) lat = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 3));
        bus.m_ack = mcnt == lat;
        mcnt++;
      end else begin
        mcnt = 0;
        bus.m_ack = $urandom_range(0, 15) == 0;
      end
      bus.m_rdata = $urandom;
      if (bus.if_req) begin
        if (bus.if_ready) begin
          if ($urandom_range(0, 1) == 0) bus.if_req = 0; else bus.if_addr = $urandom;
        end else if ($urandom_range(0, 19) == 0) bus.if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.if_req = 1; bus.if_addr = $urandom;
      end
      if (bus.d_req) begin
        if (bus.d_ready) begin
          if ($urandom_range(0, 1) == 0) bus.d_req = 0;
          else begin bus.d_addr = $urandom; bus.d_we = 1'($urandom); bus.d_wdata = $urandom; end
        end else if ($urandom_range(0, 19) == 0) bus.d_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        bus.d_req = 1; bus.d_addr = $urandom; bus.d_we = 1'($urandom); bus.d_wdata = $urandom;
      end
    end
    bus.if_req = 0; bus.d_req = 0; bus.m_ack = 0;
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the single-port unified instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (load/store). It sits between the datapath's two memory requesters and the memory.
- Grants one access at a time and holds the memory request until acknowledge.
- Returns registered data and a one-cycle ready pulse to the requester.
- Provides stall terms to the control unit, which gates pcWrite/ifidWrite and freezes the later stages.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, max cycles an access waits for m_ack before abort; must be ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  AW  fetch address
- if_ready  out  1  one-cycle pulse, fetch complete
- if_rdata  out  DW  fetched instruction, valid while if_ready
- d_req  in  1  data request, held until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ready  out  1  one-cycle pulse, data access complete
- d_rdata  out  DW  load data, valid while d_ready
- m_req  out  1  memory request, held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_ack  in  1  memory done; m_rdata valid this cycle
- m_rdata  in  DW  memory read data
- stall_if  out  1  if_req & ~if_ready
- stall_mem  out  1  d_req & ~d_ready
- err  out  1  one-cycle pulse with the ready of an aborted (timed-out) access

## Operation
- FSM states:
  - IDLE
  - IF_ACC
  - D_ACC
- IDLE:
  - Eligible requests are if_req and d_req, excluding any requester whose ready is high this cycle (that request is consumed and its still-high req is not re-granted).
  - Both eligible: D_ACC (MEM stage holds the older instruction).
  - One eligible: that access.
  - None eligible: stay in IDLE.
- At grant, the arbiter latches m_addr/m_we/m_wdata from the granted requester and clears the wait counter. For IF accesses m_we = 0.
- m_req = (state != IDLE), decoded from state.
- IF_ACC/D_ACC:
  - On m_ack: latch m_rdata into the owner's rdata register, pulse the owner's ready next cycle, go to IDLE.
  - Otherwise increment the wait counter.
  - When the counter reaches TIMEOUT-1 without m_ack: go to IDLE, pulse ready and err next cycle, rdata = 0.
- A requester dropping req mid-access does not abort the access; ready still pulses and is ignored.
- Store: d_rdata is don't-care, registered as m_rdata.
- Wait counter is clog2(TIMEOUT) bits and saturates; it never wraps.
- Reset (asynchronous, including mid-access):
  - state = IDLE, m_req = 0 immediately.
  - All registered outputs return to 0: ready/err pulses, rdata registers, m_we/m_addr/m_wdata.
  - A subsequent late m_ack in IDLE is ignored.

## Timing
- Requests are sampled on the rising edge. A request sampled in IDLE at edge t gives m_req high from cycle t+1.
- m_ack seen at edge t+k gives ready pulse during cycle t+k+1, and the state is IDLE that cycle.
- The earliest next grant is at the edge ending the ready cycle. Back-to-back throughput is one access per (memory latency + 2) cycles.
- Zero-wait memory (m_ack in the first m_req cycle): req-to-ready = 2 cycles.
- stall_if/stall_mem are combinational from req and the registered ready, so the pipeline stall drops in the same cycle ready pulses.

## Configuration
- ARB_RR_EN defined:
  - A last_grant flop (reset to IF) is updated at each grant.
  - When both are eligible in IDLE, the requester not last granted wins, so neither starves.
- ARB_RR_EN undefined: fixed priority, data over fetch; no last_grant flop.

## Structure
- Shared package mem_arb_pkg:
  - state enum {IDLE, IF_ACC, D_ACC}
  - owner encoding constants OWN_IF = 0, OWN_D = 1
  - default AW/DW
- Sub-module arb_wait_timer: saturating wait counter with clear, enable, and a timeout output. It is the only natural split.
- FSM, grant logic and response registers stay in mem_port_arbiter.

## Test plan
- **Single fetch:** if_req=1, if_addr=0x40, m_ack one cycle after m_req with m_rdata=0x2002000A. Required: m_addr=0x40, m_we=0, if_ready pulses once with if_rdata=0x2002000A, stall_if high until that cycle.
- **Simultaneous:** if_req and d_req (store, addr 0x100, wdata 0xDEADBEEF) asserted together. Required: first grant is D (m_we=1, m_addr=0x100), then IF; d_ready precedes if_ready. With ARB_RR_EN, after a prior D grant the IF request is served first.
- **Held req after ready:** requester keeps if_req high during its if_ready cycle, then drops it. Required: exactly one memory access and one ready pulse.
- **Timeout:** TIMEOUT=16, m_ack never asserted. Required: m_req high for 16 cycles then low, d_ready and err pulse together with d_rdata=0, FSM back in IDLE and accepting the next request.
- **Reset mid-access:** rst low during D_ACC, then m_ack arrives after release. Required: m_req=0 asynchronously, no ready/err pulse, the late ack is ignored.
- **Requester withdraws:** d_req drops while in D_ACC. Required: the access completes on m_ack, d_ready pulses once, no re-grant.
